ip_packet_rx: RTL
=================

IP_PACKET_RX -- requirements
Module: ip_packet_rx

Interface
REQ-001 SHALL have parameter PACKET_BYTES, 60, total frame bytes (Ethernet header + IP header + payload + pad).
REQ-002 SHALL have parameter ETH_TYPE, 16'h8000, accepted Ethernet type field.
REQ-003 SHALL have parameter IP_PROTOCOL, 8'h04, accepted IP protocol field.
REQ-004 SHALL have port ACLK  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports ACCELERATOR_IP_ADDRESS in 32 and ACCELERATOR_MAC_ADDRESS in 48, the local addresses, static.
REQ-007 SHALL have ports MAC_DATA_IN in 8, MAC_DATA_VALID in 1, MAC_DATA_LAST in 1, MAC_DATA_TUSER in 1 (frame error), MAC_DATA_READY out 1; this is the byte stream from the MAC receiver.
REQ-008 SHALL have ports SENDER_IP_ADDRESS out 32, SENDER_MAC_ADDRESS out 48, SENDER_MESSAGE out 10, MESSAGE_VALID out 1, MESSAGE_ACCEPT in 1; this is the accelerator side.
REQ-009 SHALL have port DROP_COUNT out 16, the count of discarded frames.

Function
REQ-010 Beat SHALL occur when MAC_DATA_VALID and MAC_DATA_READY are both high at the rising edge; byte index counts beats from 0.
REQ-011 Frame layout SHALL be:
- bytes 0-5: dst MAC, LSB first
- bytes 6-11: src MAC, LSB first
- bytes 12-13: type, MSB first
- bytes 14-25: version, service, length(2), id(2), flags(2), TTL, protocol, checksum(2), each 16-bit field MSB first
- bytes 26-29: src IP, LSB first
- bytes 30-33: dst IP, LSB first
- byte 34: bits[1:0] = message[9:8]
- byte 35: message[7:0]
- bytes 36-59: pad
REQ-012 States SHALL be IDLE, HEADER, PAD, DRAIN, CHECK, HOLD.
REQ-013 READY SHALL be high in IDLE/HEADER/PAD/DRAIN and low in CHECK/HOLD.
REQ-014 The first beat in IDLE SHALL be byte 0 and move the FSM to HEADER.
REQ-015 HEADER SHALL cover bytes 0-35 and then move to PAD; PAD SHALL cover bytes 36-59.
REQ-016 A frame SHALL pass only if all of these hold:
- dst MAC equals ACCELERATOR_MAC_ADDRESS or 48'hFFFFFFFFFFFF
- type equals ETH_TYPE
- version equals 8'h45
- protocol equals IP_PROTOCOL
- dst IP equals ACCELERATOR_IP_ADDRESS
- checksum is good (REQ-017)
- LAST is set on byte 59 exactly
- TUSER is low on the LAST beat
REQ-017 Checksum SHALL be the ones-complement sum with end-around carry of the ten 16-bit words {version,service}, length, id, flags, {TTL,protocol}, checksum, srcIP[31:16], srcIP[15:0], dstIP[31:16], dstIP[15:0]; it is good iff the folded sum equals 16'hFFFF.
- Words SHALL be accumulated as they complete; there SHALL be no 20-byte buffer.
REQ-018 The LAST beat at byte 59 SHALL move the FSM to CHECK for one cycle.
- CHECK SHALL go to HOLD if the frame passes, else drop and go to IDLE.
REQ-019 In HOLD, MESSAGE_VALID SHALL be high and SENDER_* SHALL be stable.
- If MESSAGE_ACCEPT is high at the edge, MESSAGE_VALID SHALL clear and the FSM SHALL go to IDLE.
- MESSAGE_VALID SHALL first rise 2 cycles after the LAST beat edge.
REQ-020 LAST before byte 59 SHALL drop the frame and return to IDLE on the next cycle.
REQ-021 No LAST on byte 59 SHALL drop the frame and go to DRAIN; DRAIN SHALL discard beats until the LAST beat, then go to IDLE.
REQ-022 Each drop SHALL increment DROP_COUNT by 1, saturating at 16'hFFFF.
REQ-023 SENDER_* SHALL update only when a frame passes; dropped frames SHALL never alter SENDER_*.
REQ-024 Idle cycles (VALID low) inside a frame SHALL not change state or byte index.

Reset
REQ-025 ARESET low at an edge SHALL force IDLE, byte index 0, accumulator 0, and clear any partial frame, regardless of state.
REQ-026 Reset output values SHALL be: MESSAGE_VALID 0, SENDER_* 0, DROP_COUNT 0, MAC_DATA_READY 0 while ARESET is low.
- MAC_DATA_READY SHALL be 1 on the first cycle after release.
REQ-027 The MAC SHALL share ARESET, so no frame is in flight at reset release.

Structure
REQ-028 The shared package SHALL hold the PACKET_BYTES, ETH_TYPE, IP_PROTOCOL and version 8'h45 constants, the byte-offset constants (0,6,12,14,24,26,30,34,35) and the FSM state enum; ip_packet_tx SHALL use the same package.
REQ-029 There SHALL be one sub-module, ipv4_checksum_accumulator: 16-bit word in, word strobe, clear, folded 16-bit sum out, registered.

Verification
REQ-030 Good frame: local IP beefbeef, local MAC 54b00bedabba, src MAC 32dabbadebd5, src IP deadbeef, message 0x1ff, valid checksum, ready-always -> MESSAGE_VALID 2 cycles after LAST with SENDER_* matching; DROP_COUNT 0.
REQ-031 Same frame with VALID low for 1, 3 and 6 cycles at bytes 4, 20 and 33, then MESSAGE_ACCEPT held low 5 cycles -> READY low and MESSAGE_VALID held through HOLD; same outputs as REQ-030.
REQ-032 Checksum byte 24 XOR 0x01 -> no MESSAGE_VALID; DROP_COUNT 1; SENDER_* unchanged.
REQ-033 dst IP deadbeee -> drop; then a broadcast dst MAC frame with correct IP -> accepted.
REQ-034 LAST at byte 40 -> drop, IDLE. A 64-byte frame with LAST at byte 63 -> DRAIN, drop. A good frame following each is accepted.
REQ-035 ARESET low for 1 cycle at byte 20 -> outputs zero. A following full good frame is accepted.

Source files
------------

// File: rtl/ip_packet_rx_pkg.sv
// Shared constants, frame offsets and FSM states for the IPv4 packet path.
// Used by both the receive and transmit sides.
package ip_packet_rx_pkg;

    localparam int          DEF_PACKET_BYTES = 60;
    localparam logic [15:0] DEF_ETH_TYPE     = 16'h8000;
    localparam logic [7:0]  DEF_IP_PROTOCOL  = 8'h04;
    localparam logic [7:0]  IP_VERSION_IHL   = 8'h45;

    localparam logic [7:0] OFF_DST_MAC = 8'd0;
    localparam logic [7:0] OFF_SRC_MAC = 8'd6;
    localparam logic [7:0] OFF_TYPE    = 8'd12;
    localparam logic [7:0] OFF_IP_HDR  = 8'd14;
    localparam logic [7:0] OFF_PROTO   = 8'd23;
    localparam logic [7:0] OFF_CSUM    = 8'd24;
    localparam logic [7:0] OFF_SRC_IP  = 8'd26;
    localparam logic [7:0] OFF_DST_IP  = 8'd30;
    localparam logic [7:0] OFF_MSG_HI  = 8'd34;
    localparam logic [7:0] OFF_MSG_LO  = 8'd35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAD,
        ST_DRAIN,
        ST_CHECK,
        ST_HOLD
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ip_packet_rx_checksum.sv
// Running ones-complement sum of 16-bit words with end-around carry.
// Sum is registered and already folded, so it is valid the cycle after a strobe.
import ip_packet_rx_pkg::*;

module ipv4_checksum_accumulator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        strobe,
    input  logic [15:0] word,
    output logic [15:0] sum
);

    logic [16:0] raw;

    // Two 16-bit addends can never carry twice, so one fold is enough.
    assign raw = {1'b0, sum} + {1'b0, word};

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sum <= '0;
        end else if (strobe) begin
            sum <= raw[15:0] + {15'd0, raw[16]};
        end
    end

endmodule

// File: rtl/ip_packet_rx.sv
// Receives fixed-size Ethernet/IPv4 frames from the MAC byte stream and
// hands the sender address and 10-bit message of each valid frame upstream.
import ip_packet_rx_pkg::*;

module ip_packet_rx #(
    parameter int          PACKET_BYTES = ip_packet_rx_pkg::DEF_PACKET_BYTES,
    parameter logic [15:0] ETH_TYPE     = ip_packet_rx_pkg::DEF_ETH_TYPE,
    parameter logic [7:0]  IP_PROTOCOL  = ip_packet_rx_pkg::DEF_IP_PROTOCOL
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] ACCELERATOR_IP_ADDRESS,
    input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
    input  logic [7:0]  MAC_DATA_IN,
    input  logic        MAC_DATA_VALID,
    input  logic        MAC_DATA_LAST,
    input  logic        MAC_DATA_TUSER,
    output logic        MAC_DATA_READY,
    output logic [31:0] SENDER_IP_ADDRESS,
    output logic [47:0] SENDER_MAC_ADDRESS,
    output logic [9:0]  SENDER_MESSAGE,
    output logic        MESSAGE_VALID,
    input  logic        MESSAGE_ACCEPT,
    output logic [15:0] DROP_COUNT
);

    localparam logic [7:0] IDX_LAST = 8'(PACKET_BYTES - 1);

    rx_state_e   state;
    logic [7:0]  idx;
    logic        beat;
    logic        take;

    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  version;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [9:0]  message;
    logic        tuser_last;

    logic [7:0]  csum_hi;
    logic [15:0] csum_word;
    logic [15:0] csum_sum;
    logic        csum_strobe;
    logic        csum_clear;
    logic        pass;

    assign beat = MAC_DATA_VALID && MAC_DATA_READY;
    assign take = beat && (state inside {ST_IDLE, ST_HEADER, ST_PAD});

    // Header words arrive MSB first, but addresses are sent LSB first.
    assign csum_word   = (idx >= OFF_SRC_IP) ? {MAC_DATA_IN, csum_hi}
                                             : {csum_hi, MAC_DATA_IN};
    assign csum_strobe = take && idx[0] &&
                         (idx > OFF_IP_HDR) && (idx < OFF_MSG_HI);
    assign csum_clear  = (state == ST_IDLE);

    ipv4_checksum_accumulator u_csum (
        .clk    (ACLK),
        .rst_n  (ARESET),
        .clear  (csum_clear),
        .strobe (csum_strobe),
        .word   (csum_word),
        .sum    (csum_sum)
    );

    assign pass = ((dst_mac == ACCELERATOR_MAC_ADDRESS) || (dst_mac == '1)) &&
                  (eth_type == ETH_TYPE) &&
                  (version == IP_VERSION_IHL) &&
                  (protocol == IP_PROTOCOL) &&
                  (dst_ip == ACCELERATOR_IP_ADDRESS) &&
                  (csum_sum == 16'hFFFF) &&
                  !tuser_last;

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            dst_mac    <= '0;
            src_mac    <= '0;
            eth_type   <= '0;
            version    <= '0;
            protocol   <= '0;
            src_ip     <= '0;
            dst_ip     <= '0;
            message    <= '0;
            csum_hi    <= '0;
            tuser_last <= 1'b0;
        end else if (take) begin
            if (idx < OFF_SRC_MAC) begin
                dst_mac <= {MAC_DATA_IN, dst_mac[47:8]};
            end else if (idx < OFF_TYPE) begin
                src_mac <= {MAC_DATA_IN, src_mac[47:8]};
            end else if (idx < OFF_IP_HDR) begin
                eth_type <= {eth_type[7:0], MAC_DATA_IN};
            end else if (idx >= OFF_SRC_IP && idx < OFF_DST_IP) begin
                src_ip <= {MAC_DATA_IN, src_ip[31:8]};
            end else if (idx >= OFF_DST_IP && idx < OFF_MSG_HI) begin
                dst_ip <= {MAC_DATA_IN, dst_ip[31:8]};
            end
            if (idx == OFF_IP_HDR) begin
                version <= MAC_DATA_IN;
            end
            if (idx == OFF_PROTO) begin
                protocol <= MAC_DATA_IN;
            end
            if (idx == OFF_MSG_HI) begin
                message[9:8] <= MAC_DATA_IN[1:0];
            end
            if (idx == OFF_MSG_LO) begin
                message[7:0] <= MAC_DATA_IN;
            end
            if (!idx[0]) begin
                csum_hi <= MAC_DATA_IN;
            end
            tuser_last <= MAC_DATA_TUSER;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            state              <= ST_IDLE;
            idx                <= '0;
            MAC_DATA_READY     <= 1'b0;
            MESSAGE_VALID      <= 1'b0;
            SENDER_IP_ADDRESS  <= '0;
            SENDER_MAC_ADDRESS <= '0;
            SENDER_MESSAGE     <= '0;
            DROP_COUNT         <= '0;
        end else begin
            MAC_DATA_READY <= 1'b1;
            unique case (state)
                ST_IDLE, ST_HEADER, ST_PAD: begin
                    if (beat) begin
                        idx <= idx + 8'd1;
                        if (MAC_DATA_LAST && idx != IDX_LAST) begin
                            DROP_COUNT <= sat_inc16(DROP_COUNT);
                            state      <= ST_IDLE;
                            idx        <= '0;
                        end else if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (MAC_DATA_LAST) begin
                                state          <= ST_CHECK;
                                MAC_DATA_READY <= 1'b0;
                            end else begin
                                DROP_COUNT <= sat_inc16(DROP_COUNT);
                                state      <= ST_DRAIN;
                            end
                        end else if (idx == OFF_MSG_LO) begin
                            state <= ST_PAD;
                        end else if (state == ST_IDLE) begin
                            state <= ST_HEADER;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (beat && MAC_DATA_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (pass) begin
                        state              <= ST_HOLD;
                        MAC_DATA_READY     <= 1'b0;
                        MESSAGE_VALID      <= 1'b1;
                        SENDER_IP_ADDRESS  <= src_ip;
                        SENDER_MAC_ADDRESS <= src_mac;
                        SENDER_MESSAGE     <= message;
                    end else begin
                        DROP_COUNT <= sat_inc16(DROP_COUNT);
                        state      <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (MESSAGE_ACCEPT) begin
                        MESSAGE_VALID <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        MAC_DATA_READY <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
